sync_fifo_cfg: RTL and testbench
================================

# sync_fifo_cfg

Single-clock, parametrised FIFO for buffering data between producer and consumer blocks in the same clock domain. It supports any depth of at least 2, including non-power-of-two depths. A parameter selects standard or first-word-fall-through (FWFT) read mode. The block adds programmable almost-full/almost-empty flags, overflow/underflow pulses, a synchronous flush, and read/write in the same cycle while full.

## Interface
- DATA_WIDTH, 64, word width in bits
- DEPTH, 512, capacity in words; must be ≥2; power of two not required
- FWFT, 0, read mode: 0 = standard, 1 = first-word-fall-through
- AF_THRESH, DEPTH-4, o_almost_full asserts when count ≥ AF_THRESH; range 1..DEPTH
- AE_THRESH, 4, o_almost_empty asserts when count ≤ AE_THRESH; range 0..DEPTH-1
- CW: localparam, $clog2(DEPTH+1)

Ports:
- i_clk  in  1  single clock, all logic on rising edge
- i_rstn  in  1  asynchronous, active-low reset
- i_flush  in  1  synchronous clear, highest priority
- i_wr_en  in  1  write request
- i_wr_data  in  DATA_WIDTH  write data
- o_full  out  1  count == DEPTH
- o_almost_full  out  1  count ≥ AF_THRESH
- o_overflow  out  1  one-cycle pulse: a write was rejected on the previous edge
- i_rd_en  in  1  read request (FWFT: acknowledge of the presented word)
- o_rd_data  out  DATA_WIDTH  read data
- o_rd_valid  out  1  standard: one-cycle pulse with new data; FWFT: head word present
- o_empty  out  1  standard: count == 0; FWFT: !o_rd_valid
- o_almost_empty  out  1  count ≤ AE_THRESH
- o_underflow  out  1  one-cycle pulse: a read was rejected on the previous edge
- o_data_count  out  CW  words held (FWFT: includes the output-stage word)

## Operation
- Acceptance, evaluated on pre-edge state:
  - rd_ok = i_rd_en && count > 0; in FWFT mode the condition is o_rd_valid.
  - wr_ok = i_wr_en && (count < DEPTH || rd_ok).
- Read and write in the same cycle while full: both are accepted and count is unchanged.
- Read and write in the same cycle while empty: write is accepted, read is rejected and o_underflow pulses.
- Count update: count + wr_ok − rd_ok. Count never exceeds DEPTH and never goes below 0.
- Pointers: wr_ptr and rd_ptr are $clog2(DEPTH) bits wide and wrap from DEPTH-1 to 0 by explicit compare, not natural overflow.
- Standard mode:
  - On rd_ok, o_rd_data is loaded with mem[rd_ptr] and o_rd_valid is 1 for exactly one cycle.
  - Otherwise o_rd_data holds its previous value.
- FWFT mode:
  - A registered output stage holds the head word. It is refilled from memory, or directly from i_wr_data when memory is empty, on any edge where the stage is empty or being acknowledged.
  - o_rd_valid stays high while a word is presented.
  - Total storage is capped at DEPTH words.
- Flags: o_full, o_almost_full, o_almost_empty and o_empty are registered, computed from the next count, and therefore coherent with o_data_count in every cycle.
- o_overflow = registered (i_wr_en && !wr_ok); o_underflow = registered (i_rd_en && !rd_ok). Both are ignored during flush.
- i_flush: pointers, count, output stage, o_rd_valid and pulse flags return to their reset values on the next edge. Same-cycle writes and reads are discarded. Memory contents are not cleared.
- Reset (i_rstn low, asynchronous):
  - Return to 0: o_rd_data, o_rd_valid, o_full, o_almost_full, o_overflow, o_underflow, o_data_count, and both pointers.
  - Return to 1: o_empty, o_almost_empty.
  - Reset mid-operation discards all contents. Memory is not reset.

## Timing
- Write to read visibility:
  - Standard: a word written at edge N is readable by i_rd_en asserted in cycle N+1; data appears at edge N+2.
  - FWFT, empty FIFO: o_rd_valid=1 with the word on o_rd_data after edge N+1.
- Read latency:
  - Standard: 1 cycle from i_rd_en to o_rd_data/o_rd_valid.
  - FWFT: 0 cycles; data is already present and the acknowledge pops on the edge.
- Sustained throughput: 1 write and 1 read per cycle, including at full and at empty+1.
- All flag and count changes appear exactly 1 edge after the causing request.
- No combinational path from any input to any output.

## Test plan
- **Reset, standard mode:** DEPTH=8, FWFT=0; reset, then write 8 words 0x1..0x8.
  - o_full rises after the 8th edge; o_data_count=8; o_almost_full rises when count reaches 4 (AF_THRESH=4).
  - A 9th write pulses o_overflow once and count stays 8.
- **Read-out and underflow:** read all 8 words.
  - o_rd_data sequence 0x1..0x8, each one cycle after i_rd_en, with o_rd_valid pulses.
  - o_empty=1 after the last read; a further read pulses o_underflow and o_rd_data holds 0x8.
- **Simultaneous full/empty access:**
  - Full FIFO with simultaneous write 0x9 and read: read returns 0x1, count stays 8, no overflow.
  - Empty FIFO with simultaneous write and read: count becomes 1 and o_underflow pulses.
- **Non-power-of-two wrap:** DEPTH=5; stream 20 words at 1 write + 1 read per cycle after priming with 2.
  - Output equals input order with no gaps or duplicates; pointers wrap at 4→0.
- **FWFT:** FWFT=1; write 0xA5 to an empty FIFO.
  - o_rd_valid=1 and o_rd_data=0xA5 after the next edge.
  - Holding i_rd_en=0 keeps them stable; asserting i_rd_en pops the word, o_empty=1 on the next edge, count 0.
- **Flush and reset mid-operation:**
  - With 3 words held, i_flush=1 together with i_wr_en=1: on the next edge count=0, o_empty=1, and the write is discarded.
  - Asserting i_rstn=0 asynchronously mid-stream immediately forces all outputs to their reset values.

Source files
------------

// File: rtl/sync_fifo_cfg.sv
// sync_fifo_cfg
// Single-clock FIFO with a configurable depth. The depth does not have to be a
// power of two. FWFT selects the read mode:
//   FWFT=0 (standard): a read is accepted on the clock edge. The word appears
//     on o_rd_data one cycle later, and o_rd_valid pulses for that one cycle.
//   FWFT=1: the head word is held in a registered output stage. o_rd_valid
//     stays high while that word is presented, and i_rd_en pops it.
// All outputs are registered. Flags are computed from the next count, so they
// always agree with o_data_count.
//
// Ports:
//   i_clk, i_rstn    clock (rising edge), asynchronous active-low reset
//   i_flush          synchronous clear; takes priority over read and write
//   i_wr_en/i_wr_data, o_full, o_almost_full, o_overflow       write side
//   i_rd_en, o_rd_data, o_rd_valid, o_empty, o_almost_empty,
//   o_underflow                                                read side
//   o_data_count     words held (FWFT: includes the output-stage word)
module sync_fifo_cfg #(
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 512,
  parameter int FWFT       = 0,
  parameter int AF_THRESH  = DEPTH - 4,
  parameter int AE_THRESH  = 4,
  localparam int CW        = $clog2(DEPTH + 1)
) (
  input  logic                  i_clk,
  input  logic                  i_rstn,
  input  logic                  i_flush,
  input  logic                  i_wr_en,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  output logic                  o_full,
  output logic                  o_almost_full,
  output logic                  o_overflow,
  input  logic                  i_rd_en,
  output logic [DATA_WIDTH-1:0] o_rd_data,
  output logic                  o_rd_valid,
  output logic                  o_empty,
  output logic                  o_almost_empty,
  output logic                  o_underflow,
  output logic [CW-1:0]         o_data_count
);

  localparam int PW = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [PW-1:0]         wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0]         count_reg, count_next, mem_cnt;
  logic [DATA_WIDTH-1:0] rd_data_reg;
  logic                  valid_reg, valid_next;
  logic                  full_reg, af_reg, ae_reg, empty_reg, ovf_reg, unf_reg;
  logic                  rd_ok, wr_ok, load, mem_re, mem_we, bypass;

  // Pointers wrap by an explicit compare, so a non-power-of-two depth works.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    // In FWFT mode count_reg includes the staged word. mem_cnt is the number
    // of words still in the array.
    mem_cnt = count_reg - CW'(valid_reg);
    if (FWFT != 0) rd_ok = i_rd_en && valid_reg;
    else           rd_ok = i_rd_en && (count_reg != '0);
    // A write into a full FIFO is accepted when a read frees a slot on the
    // same edge.
    wr_ok      = i_wr_en && ((count_reg != CW'(DEPTH)) || rd_ok);
    load       = 1'b0;
    bypass     = 1'b0;
    mem_re     = rd_ok;
    mem_we     = wr_ok;
    valid_next = rd_ok;
    if (FWFT != 0) begin
      // The stage reloads when it is empty or its word is being taken.
      // If the array is empty, incoming write data goes straight to the stage.
      load       = !valid_reg || rd_ok;
      mem_re     = load && (mem_cnt != '0);
      bypass     = load && (mem_cnt == '0) && wr_ok;
      mem_we     = wr_ok && !bypass;
      valid_next = load ? (mem_re || bypass) : 1'b1;
    end
    count_next = count_reg + CW'(wr_ok) - CW'(rd_ok);
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      count_reg   <= '0;
      rd_data_reg <= '0;
      valid_reg   <= 1'b0;
      full_reg    <= 1'b0;
      af_reg      <= 1'b0;
      ae_reg      <= 1'b1;
      empty_reg   <= 1'b1;
      ovf_reg     <= 1'b0;
      unf_reg     <= 1'b0;
    end else if (i_flush) begin
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      count_reg   <= '0;
      rd_data_reg <= '0;
      valid_reg   <= 1'b0;
      full_reg    <= 1'b0;
      af_reg      <= 1'b0;
      ae_reg      <= 1'b1;
      empty_reg   <= 1'b1;
      ovf_reg     <= 1'b0;
      unf_reg     <= 1'b0;
    end else begin
      count_reg <= count_next;
      if (mem_we) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      if (mem_re) rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      // A read of the array returns the old word, even when the write pointer
      // points at the same slot in the same cycle.
      if (mem_re)      rd_data_reg <= mem[rd_ptr_reg];
      else if (bypass) rd_data_reg <= i_wr_data;
      valid_reg <= valid_next;
      full_reg  <= (count_next == CW'(DEPTH));
      af_reg    <= (count_next >= CW'(AF_THRESH));
      ae_reg    <= (count_next <= CW'(AE_THRESH));
      empty_reg <= (FWFT != 0) ? !valid_next : (count_next == '0);
      ovf_reg   <= i_wr_en && !wr_ok;
      unf_reg   <= i_rd_en && !rd_ok;
    end
  end

  // The storage array has no reset, so it can map onto block RAM.
  always_ff @(posedge i_clk) begin
    if (mem_we && !i_flush) mem[wr_ptr_reg] <= i_wr_data;
  end

  assign o_full         = full_reg;
  assign o_almost_full  = af_reg;
  assign o_overflow     = ovf_reg;
  assign o_rd_data      = rd_data_reg;
  assign o_rd_valid     = valid_reg;
  assign o_empty        = empty_reg;
  assign o_almost_empty = ae_reg;
  assign o_underflow    = unf_reg;
  assign o_data_count   = count_reg;

endmodule

// File: tb/tb_sync_fifo_cfg.sv
// tb_sync_fifo_cfg
// Three instances: A (DEPTH=8, standard, AF=4, AE=2), B (DEPTH=5, standard,
// AF=5, AE=0) and C (DEPTH=8, FWFT, AF=6, AE=1). The expected outputs come
// from a queue-based model of the FIFO rules.
module tb_sync_fifo_cfg;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic        a_flush = 0, a_wr = 0, a_rd = 0;
  logic [15:0] a_din = 0, a_dout;
  logic        a_full, a_af, a_ovf, a_valid, a_empty, a_ae, a_unf;
  logic [3:0]  a_cnt;
  logic        b_flush = 0, b_wr = 0, b_rd = 0;
  logic [15:0] b_din = 0, b_dout;
  logic        b_full, b_af, b_ovf, b_valid, b_empty, b_ae, b_unf;
  logic [2:0]  b_cnt;
  logic        c_flush = 0, c_wr = 0, c_rd = 0;
  logic [15:0] c_din = 0, c_dout;
  logic        c_full, c_af, c_ovf, c_valid, c_empty, c_ae, c_unf;
  logic [3:0]  c_cnt;

  sync_fifo_cfg #(.DATA_WIDTH(16), .DEPTH(8), .FWFT(0), .AF_THRESH(4), .AE_THRESH(2)) u_a (
    .i_clk(clk), .i_rstn(rstn), .i_flush(a_flush), .i_wr_en(a_wr), .i_wr_data(a_din),
    .o_full(a_full), .o_almost_full(a_af), .o_overflow(a_ovf), .i_rd_en(a_rd),
    .o_rd_data(a_dout), .o_rd_valid(a_valid), .o_empty(a_empty), .o_almost_empty(a_ae),
    .o_underflow(a_unf), .o_data_count(a_cnt));

  sync_fifo_cfg #(.DATA_WIDTH(16), .DEPTH(5), .FWFT(0), .AF_THRESH(5), .AE_THRESH(0)) u_b (
    .i_clk(clk), .i_rstn(rstn), .i_flush(b_flush), .i_wr_en(b_wr), .i_wr_data(b_din),
    .o_full(b_full), .o_almost_full(b_af), .o_overflow(b_ovf), .i_rd_en(b_rd),
    .o_rd_data(b_dout), .o_rd_valid(b_valid), .o_empty(b_empty), .o_almost_empty(b_ae),
    .o_underflow(b_unf), .o_data_count(b_cnt));

  sync_fifo_cfg #(.DATA_WIDTH(16), .DEPTH(8), .FWFT(1), .AF_THRESH(6), .AE_THRESH(1)) u_c (
    .i_clk(clk), .i_rstn(rstn), .i_flush(c_flush), .i_wr_en(c_wr), .i_wr_data(c_din),
    .o_full(c_full), .o_almost_full(c_af), .o_overflow(c_ovf), .i_rd_en(c_rd),
    .o_rd_data(c_dout), .o_rd_valid(c_valid), .o_empty(c_empty), .o_almost_empty(c_ae),
    .o_underflow(c_unf), .o_data_count(c_cnt));

  int errors = 0;
  int checks = 0;

  // Reference model: a queue of held words per instance, plus the expected
  // value of each output register.
  logic [15:0] q_a[$], q_b[$], q_c[$], q[$];
  int          m_depth[3], m_fwft[3], m_af[3], m_ae[3];
  logic [15:0] e_data[3];
  bit          e_known[3], e_valid[3], e_ovf[3], e_unf[3];
  int          e_count[3];

  // Outputs sampled from the instance under test.
  logic [15:0] o_data;
  logic        o_valid, o_full, o_af, o_ovf, o_empty, o_ae, o_unf;
  int          o_count;

  task automatic model_reset_all();
    q_a.delete(); q_b.delete(); q_c.delete();
    for (int i = 0; i < 3; i++) begin
      e_data[i] = 16'h0; e_known[i] = 1'b1; e_valid[i] = 1'b0;
      e_ovf[i] = 1'b0; e_unf[i] = 1'b0; e_count[i] = 0;
    end
  endtask

  task automatic model_step(input int i, input bit wr, input logic [15:0] din,
                            input bit rd, input bit fl);
    bit rd_ok, wr_ok;
    case (i)
      0: q = q_a;
      1: q = q_b;
      default: q = q_c;
    endcase
    if (fl) begin
      q.delete();
      e_valid[i] = 1'b0; e_ovf[i] = 1'b0; e_unf[i] = 1'b0; e_known[i] = 1'b0;
    end else begin
      rd_ok = rd && (q.size() > 0);
      wr_ok = wr && ((q.size() < m_depth[i]) || rd_ok);
      e_ovf[i] = wr && !wr_ok;
      e_unf[i] = rd && !rd_ok;
      if (m_fwft[i] == 0) begin
        e_valid[i] = rd_ok;
        if (rd_ok) begin e_data[i] = q[0]; e_known[i] = 1'b1; end
      end
      if (rd_ok) void'(q.pop_front());
      if (wr_ok) q.push_back(din);
      if (m_fwft[i] != 0) begin
        e_valid[i] = (q.size() > 0);
        if (e_valid[i]) begin e_data[i] = q[0]; e_known[i] = 1'b1; end
      end
    end
    e_count[i] = q.size();
    case (i)
      0: q_a = q;
      1: q_b = q;
      default: q_c = q;
    endcase
  endtask

  task automatic sample(input int i);
    case (i)
      0: begin o_data = a_dout; o_valid = a_valid; o_full = a_full; o_af = a_af; o_ovf = a_ovf;
               o_empty = a_empty; o_ae = a_ae; o_unf = a_unf; o_count = int'(a_cnt); end
      1: begin o_data = b_dout; o_valid = b_valid; o_full = b_full; o_af = b_af; o_ovf = b_ovf;
               o_empty = b_empty; o_ae = b_ae; o_unf = b_unf; o_count = int'(b_cnt); end
      default: begin o_data = c_dout; o_valid = c_valid; o_full = c_full; o_af = c_af; o_ovf = c_ovf;
               o_empty = c_empty; o_ae = c_ae; o_unf = c_unf; o_count = int'(c_cnt); end
    endcase
  endtask

  // One clock cycle on instance i. Inputs are applied between edges, the
  // model is advanced, and outputs are sampled 1 time unit after the edge.
  task automatic cyc(input int i, input bit wr, input logic [15:0] din, input bit rd, input bit fl);
    case (i)
      0: begin a_wr = wr; a_din = din; a_rd = rd; a_flush = fl; end
      1: begin b_wr = wr; b_din = din; b_rd = rd; b_flush = fl; end
      default: begin c_wr = wr; c_din = din; c_rd = rd; c_flush = fl; end
    endcase
    @(posedge clk);
    #1;
    case (i)
      0: begin a_wr = 0; a_rd = 0; a_flush = 0; end
      1: begin b_wr = 0; b_rd = 0; b_flush = 0; end
      default: begin c_wr = 0; c_rd = 0; c_flush = 0; end
    endcase
    model_step(i, wr, din, rd, fl);
    sample(i);
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    #12;
    sample(0);
    checks++; if (o_count !== 0) begin errors++; $display("FAIL reset_count: got %0d want 0", o_count); end
    checks++; if (o_empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b want 1", o_empty); end
    checks++; if (o_ae !== 1'b1) begin errors++; $display("FAIL reset_almost_empty: got %b want 1", o_ae); end
    checks++; if (o_full !== 1'b0 || o_af !== 1'b0) begin errors++; $display("FAIL reset_full_af: got %b%b want 00", o_full, o_af); end
    checks++; if (o_valid !== 1'b0 || o_data !== 16'h0) begin errors++; $display("FAIL reset_rd: got valid=%b data=%h want 0/0000", o_valid, o_data); end
    checks++; if (o_ovf !== 1'b0 || o_unf !== 1'b0) begin errors++; $display("FAIL reset_pulses: got %b%b want 00", o_ovf, o_unf); end
    sample(2);
    checks++; if (o_valid !== 1'b0 || o_empty !== 1'b1) begin errors++; $display("FAIL reset_fwft: got valid=%b empty=%b want 0/1", o_valid, o_empty); end
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_fill();
    for (int k = 1; k <= 8; k++) begin
      cyc(0, 1, 16'(k), 0, 0);
      checks++; if (o_count !== e_count[0]) begin errors++; $display("FAIL fill_count[%0d]: got %0d want %0d", k, o_count, e_count[0]); end
      checks++; if (o_af !== (e_count[0] >= 4)) begin errors++; $display("FAIL fill_af[%0d]: got %b want %b", k, o_af, e_count[0] >= 4); end
      checks++; if (o_full !== (e_count[0] == 8)) begin errors++; $display("FAIL fill_full[%0d]: got %b want %b", k, o_full, e_count[0] == 8); end
    end
    cyc(0, 1, 16'h00FF, 0, 0);
    checks++; if (o_ovf !== 1'b1) begin errors++; $display("FAIL overflow_pulse: got %b want 1", o_ovf); end
    checks++; if (o_count !== 8) begin errors++; $display("FAIL overflow_count: got %0d want 8", o_count); end
    cyc(0, 0, 16'h0, 0, 0);
    checks++; if (o_ovf !== 1'b0) begin errors++; $display("FAIL overflow_once: got %b want 0", o_ovf); end
  endtask

  task automatic test_readout();
    for (int k = 1; k <= 8; k++) begin
      cyc(0, 0, 16'h0, 1, 0);
      checks++; if (o_valid !== 1'b1 || o_data !== e_data[0]) begin errors++; $display("FAIL read_data[%0d]: got valid=%b data=%h want 1/%h", k, o_valid, o_data, e_data[0]); end
      checks++; if (o_empty !== (e_count[0] == 0) || o_ae !== (e_count[0] <= 2)) begin errors++; $display("FAIL read_flags[%0d]: got empty=%b ae=%b count_model=%0d", k, o_empty, o_ae, e_count[0]); end
    end
    cyc(0, 0, 16'h0, 1, 0);
    checks++; if (o_unf !== 1'b1 || o_valid !== 1'b0) begin errors++; $display("FAIL underflow_pulse: got unf=%b valid=%b want 1/0", o_unf, o_valid); end
    checks++; if (o_data !== 16'h0008) begin errors++; $display("FAIL underflow_hold: got %h want 0008", o_data); end
    cyc(0, 0, 16'h0, 0, 0);
    checks++; if (o_unf !== 1'b0) begin errors++; $display("FAIL underflow_once: got %b want 0", o_unf); end
  endtask

  task automatic test_full_empty_rw();
    for (int k = 1; k <= 8; k++) cyc(0, 1, 16'(k), 0, 0);
    checks++; if (o_full !== 1'b1) begin errors++; $display("FAIL refill_full: got %b want 1", o_full); end
    cyc(0, 1, 16'h0009, 1, 0);
    checks++; if (o_data !== 16'h0001 || o_valid !== 1'b1) begin errors++; $display("FAIL full_rw_data: got %h/%b want 0001/1", o_data, o_valid); end
    checks++; if (o_count !== 8 || o_ovf !== 1'b0) begin errors++; $display("FAIL full_rw_count: got count=%0d ovf=%b want 8/0", o_count, o_ovf); end
    cyc(0, 0, 16'h0, 0, 1);
    checks++; if (o_count !== 0 || o_empty !== 1'b1) begin errors++; $display("FAIL flush_clear: got count=%0d empty=%b want 0/1", o_count, o_empty); end
    cyc(0, 1, 16'h0077, 1, 0);
    checks++; if (o_count !== 1 || o_unf !== 1'b1) begin errors++; $display("FAIL empty_rw: got count=%0d unf=%b want 1/1", o_count, o_unf); end
    cyc(0, 0, 16'h0, 1, 0);
    checks++; if (o_data !== 16'h0077) begin errors++; $display("FAIL empty_rw_data: got %h want 0077", o_data); end
  endtask

  task automatic test_flush();
    for (int k = 0; k < 3; k++) cyc(0, 1, 16'(16'h40 + k), 0, 0);
    cyc(0, 1, 16'h0055, 0, 1);
    checks++; if (o_count !== 0 || o_empty !== 1'b1 || o_full !== 1'b0) begin errors++; $display("FAIL flush_wr: got count=%0d empty=%b full=%b want 0/1/0", o_count, o_empty, o_full); end
    cyc(0, 0, 16'h0, 1, 0);
    checks++; if (o_unf !== 1'b1 || o_valid !== 1'b0) begin errors++; $display("FAIL flush_discard: got unf=%b valid=%b want 1/0", o_unf, o_valid); end
  endtask

  task automatic test_wrap();
    cyc(1, 1, 16'($urandom), 0, 0);
    cyc(1, 1, 16'($urandom), 0, 0);
    for (int k = 0; k < 20; k++) begin
      cyc(1, 1, 16'($urandom), 1, 0);
      checks++; if (o_valid !== 1'b1 || o_data !== e_data[1]) begin errors++; $display("FAIL wrap_data[%0d]: got valid=%b data=%h want 1/%h", k, o_valid, o_data, e_data[1]); end
      checks++; if (o_count !== 2) begin errors++; $display("FAIL wrap_count[%0d]: got %0d want 2", k, o_count); end
    end
    for (int k = 0; k < 2; k++) begin
      cyc(1, 0, 16'h0, 1, 0);
      checks++; if (o_data !== e_data[1]) begin errors++; $display("FAIL wrap_drain[%0d]: got %h want %h", k, o_data, e_data[1]); end
    end
  endtask

  task automatic test_fwft();
    cyc(2, 1, 16'h00A5, 0, 0);
    checks++; if (o_valid !== 1'b1 || o_data !== 16'h00A5) begin errors++; $display("FAIL fwft_present: got valid=%b data=%h want 1/00a5", o_valid, o_data); end
    checks++; if (o_count !== 1 || o_empty !== 1'b0) begin errors++; $display("FAIL fwft_count: got count=%0d empty=%b want 1/0", o_count, o_empty); end
    for (int k = 0; k < 3; k++) begin
      cyc(2, 0, 16'h0, 0, 0);
      checks++; if (o_valid !== 1'b1 || o_data !== 16'h00A5) begin errors++; $display("FAIL fwft_hold[%0d]: got valid=%b data=%h want 1/00a5", k, o_valid, o_data); end
    end
    cyc(2, 0, 16'h0, 1, 0);
    checks++; if (o_empty !== 1'b1 || o_count !== 0 || o_valid !== 1'b0) begin errors++; $display("FAIL fwft_pop: got empty=%b count=%0d valid=%b want 1/0/0", o_empty, o_count, o_valid); end
  endtask

  task automatic test_random(input int i, input int n);
    bit wr, rd, fl;
    int pw, pr;
    for (int k = 0; k < n; k++) begin
      pw = (k < n / 2) ? 70 : 35;
      pr = (k < n / 2) ? 40 : 70;
      wr = ($urandom_range(0, 99) < pw);
      rd = ($urandom_range(0, 99) < pr);
      fl = ($urandom_range(0, 99) == 0);
      cyc(i, wr, 16'($urandom), rd, fl);
      checks++; if (o_count !== e_count[i]) begin errors++; $display("FAIL rand%0d_count[%0d]: got %0d want %0d", i, k, o_count, e_count[i]); end
      checks++; if (o_full !== (e_count[i] == m_depth[i]) || o_af !== (e_count[i] >= m_af[i])) begin errors++; $display("FAIL rand%0d_full_af[%0d]: got %b%b count_model=%0d", i, k, o_full, o_af, e_count[i]); end
      checks++; if (o_empty !== (e_count[i] == 0) || o_ae !== (e_count[i] <= m_ae[i])) begin errors++; $display("FAIL rand%0d_empty_ae[%0d]: got %b%b count_model=%0d", i, k, o_empty, o_ae, e_count[i]); end
      checks++; if (o_valid !== e_valid[i]) begin errors++; $display("FAIL rand%0d_valid[%0d]: got %b want %b", i, k, o_valid, e_valid[i]); end
      checks++; if (o_ovf !== e_ovf[i] || o_unf !== e_unf[i]) begin errors++; $display("FAIL rand%0d_pulses[%0d]: got ovf=%b unf=%b want %b/%b", i, k, o_ovf, o_unf, e_ovf[i], e_unf[i]); end
      if ((m_fwft[i] != 0) ? e_valid[i] : e_known[i]) begin
        checks++; if (o_data !== e_data[i]) begin errors++; $display("FAIL rand%0d_data[%0d]: got %h want %h", i, k, o_data, e_data[i]); end
      end
    end
  endtask

  task automatic test_async_reset();
    for (int k = 0; k < 3; k++) cyc(0, 1, 16'(16'h30 + k), 0, 0);
    cyc(0, 0, 16'h0, 1, 0);
    for (int k = 0; k < 3; k++) cyc(2, 1, 16'(16'h60 + k), 0, 0);
    #2;
    rstn = 1'b0;
    #1;
    sample(0);
    checks++; if (o_count !== 0 || o_empty !== 1'b1 || o_ae !== 1'b1) begin errors++; $display("FAIL async_rst_a_count: got count=%0d empty=%b ae=%b want 0/1/1", o_count, o_empty, o_ae); end
    checks++; if (o_data !== 16'h0 || o_valid !== 1'b0 || o_af !== 1'b0) begin errors++; $display("FAIL async_rst_a_rd: got data=%h valid=%b af=%b want 0000/0/0", o_data, o_valid, o_af); end
    sample(2);
    checks++; if (o_count !== 0 || o_valid !== 1'b0 || o_empty !== 1'b1) begin errors++; $display("FAIL async_rst_c: got count=%0d valid=%b empty=%b want 0/0/1", o_count, o_valid, o_empty); end
    model_reset_all();
    @(negedge clk);
    rstn = 1'b1;
    cyc(0, 1, 16'h0012, 0, 0);
    cyc(0, 0, 16'h0, 1, 0);
    checks++; if (o_data !== 16'h0012 || o_count !== 0) begin errors++; $display("FAIL post_reset_rw: got data=%h count=%0d want 0012/0", o_data, o_count); end
  endtask

  initial begin
    m_depth = '{8, 5, 8};
    m_fwft  = '{0, 0, 1};
    m_af    = '{4, 5, 6};
    m_ae    = '{2, 0, 1};
    model_reset_all();
    test_reset();
    test_fill();
    test_readout();
    test_full_empty_rw();
    test_flush();
    test_wrap();
    test_fwft();
    test_random(1, 300);
    test_random(2, 300);
    test_random(0, 300);
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
